// File: rtl/pipe_control_unit.sv
// Pipelined MIPS main control: decodes the IF/ID instruction, carries the control word through
// ID/EX, EX/MEM and MEM/WB, and detects load-use hazards.
module pipe_control_unit #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned REG_W   = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instruction,
  input  logic               InstrValid,
  input  logic               Flush,
  output logic               Stall,
  output logic               EX_RegDst,
  output logic               EX_ALUSrc,
  output logic               EX_ZeroExt,
  output logic               EX_Branch,
  output logic               EX_BranchNe,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic               EX_IllegalOp,
  output logic               MEM_MemRead,
  output logic               MEM_MemWrite,
  output logic               WB_RegWrite,
  output logic               WB_MemtoReg,
  output logic [REG_W-1:0]   WB_WriteReg
);

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic               zeroext;
    logic               branch;
    logic               branchne;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
    logic [REG_W-1:0]   wreg;
  } ctrl_t;

  logic [5:0]       opcode;
  logic [REG_W-1:0] rs, rt, rd;
  logic [3:0]       aluop4;
  logic             use_rs, use_rt;
  logic             hazard, bubble;
  ctrl_t            id_ctrl, idex_d, idex_q;

  logic             exmem_memread_q, exmem_memwrite_q, exmem_regwrite_q, exmem_memtoreg_q;
  logic [REG_W-1:0] exmem_wreg_q;
  logic             memwb_regwrite_q, memwb_memtoreg_q;
  logic [REG_W-1:0] memwb_wreg_q;

  logic unused_instr_bits;
  assign unused_instr_bits = ^Instruction[10:0];

  assign opcode = Instruction[31:26];
  assign rs     = REG_W'(Instruction[25:21]);
  assign rt     = REG_W'(Instruction[20:16]);
  assign rd     = REG_W'(Instruction[15:11]);

  always_comb begin
    id_ctrl = '0;
    aluop4  = 4'b0000;
    use_rs  = 1'b1;
    use_rt  = 1'b0;
    case (opcode)
      6'b000000: begin id_ctrl.regdst = 1'b1; aluop4 = 4'b0010; id_ctrl.regwrite = 1'b1;
                       use_rt = 1'b1; end
      6'b011100: begin id_ctrl.regdst = 1'b1; aluop4 = 4'b1000; id_ctrl.regwrite = 1'b1;
                       use_rt = 1'b1; end
      6'b001000,
      6'b001001: begin id_ctrl.alusrc = 1'b1; id_ctrl.regwrite = 1'b1; end
      6'b001100: begin id_ctrl.alusrc = 1'b1; id_ctrl.zeroext = 1'b1; aluop4 = 4'b0011;
                       id_ctrl.regwrite = 1'b1; end
      6'b001101: begin id_ctrl.alusrc = 1'b1; id_ctrl.zeroext = 1'b1; aluop4 = 4'b0100;
                       id_ctrl.regwrite = 1'b1; end
      6'b001110: begin id_ctrl.alusrc = 1'b1; id_ctrl.zeroext = 1'b1; aluop4 = 4'b0101;
                       id_ctrl.regwrite = 1'b1; end
      6'b001010: begin id_ctrl.alusrc = 1'b1; aluop4 = 4'b0110; id_ctrl.regwrite = 1'b1; end
      6'b001011: begin id_ctrl.alusrc = 1'b1; aluop4 = 4'b0111; id_ctrl.regwrite = 1'b1; end
      6'b100011: begin id_ctrl.alusrc = 1'b1; id_ctrl.memread = 1'b1; id_ctrl.memtoreg = 1'b1;
                       id_ctrl.regwrite = 1'b1; end
      6'b101011: begin id_ctrl.alusrc = 1'b1; id_ctrl.memwrite = 1'b1; use_rt = 1'b1; end
      6'b000100: begin aluop4 = 4'b0001; id_ctrl.branch = 1'b1; use_rt = 1'b1; end
      6'b000101: begin aluop4 = 4'b0001; id_ctrl.branch = 1'b1; id_ctrl.branchne = 1'b1;
                       use_rt = 1'b1; end
      default:   begin id_ctrl.illegal = 1'b1; use_rs = 1'b0; end
    endcase
    id_ctrl.aluop = ALUOP_W'(aluop4);
    id_ctrl.wreg  = id_ctrl.regdst ? rd : rt;
    // Writes to $zero are architectural no-ops; dropping them also keeps them out of hazards.
    if (id_ctrl.wreg == '0) id_ctrl.regwrite = 1'b0;
  end

  assign hazard = InstrValid & idex_q.memread & (idex_q.wreg != '0) &
                  ((use_rs & (idex_q.wreg == rs)) | (use_rt & (idex_q.wreg == rt)));
  assign Stall  = hazard & ~Flush;
  assign bubble = ~InstrValid | Flush | hazard | id_ctrl.illegal;

  always_comb begin
    idex_d = '0;
    if (!bubble) idex_d = id_ctrl;
    // An illegal opcode still reports itself from EX even though it executes as a bubble.
    idex_d.illegal = InstrValid & id_ctrl.illegal & ~Flush;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idex_q           <= '0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_regwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_wreg_q     <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_wreg_q     <= '0;
    end else begin
      idex_q           <= idex_d;
      exmem_memread_q  <= idex_q.memread;
      exmem_memwrite_q <= idex_q.memwrite;
      exmem_regwrite_q <= idex_q.regwrite;
      exmem_memtoreg_q <= idex_q.memtoreg;
      exmem_wreg_q     <= idex_q.wreg;
      memwb_regwrite_q <= exmem_regwrite_q;
      memwb_memtoreg_q <= exmem_memtoreg_q;
      memwb_wreg_q     <= exmem_wreg_q;
    end
  end

  assign EX_RegDst    = idex_q.regdst;
  assign EX_ALUSrc    = idex_q.alusrc;
  assign EX_ZeroExt   = idex_q.zeroext;
  assign EX_Branch    = idex_q.branch;
  assign EX_BranchNe  = idex_q.branchne;
  assign EX_ALUOp     = idex_q.aluop;
  assign EX_IllegalOp = idex_q.illegal;
  assign MEM_MemRead  = exmem_memread_q;
  assign MEM_MemWrite = exmem_memwrite_q;
  assign WB_RegWrite  = memwb_regwrite_q;
  assign WB_MemtoReg  = memwb_memtoreg_q;
  assign WB_WriteReg  = memwb_wreg_q;

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined main control unit for the MIPS datapath. It decodes the ID-stage instruction into a control word, which now covers the immediate-ALU, SPECIAL2, load/store and BEQ/BNE opcodes. It carries that word through ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards and inserts bubbles on stall or flush. It sits between the IF/ID register and the EX/MEM/WB datapath muxes, and replaces the combinational decoder.

## Interface
- ALUOP_W, 4, width of ALUOp field; must be >= 4
- REG_W, 5, register-address width
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Instruction  in  32  instruction held in IF/ID
- InstrValid  in  1  IF/ID holds a real instruction; 0 decodes as bubble
- Flush  in  1  branch taken; squash the ID instruction
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- EX_RegDst, EX_ALUSrc, EX_ZeroExt, EX_Branch, EX_BranchNe  out  1 each  EX-stage controls
- EX_ALUOp  out  ALUOP_W  EX-stage ALU operation
- EX_IllegalOp  out  1  EX holds an undecodable opcode (already a bubble)
- MEM_MemRead, MEM_MemWrite  out  1 each  MEM-stage controls
- WB_RegWrite, WB_MemtoReg  out  1 each  WB-stage controls
- WB_WriteReg  out  REG_W  WB destination register

## Operation

**Decode (ID, combinational), keyed on opcode [31:26]:**
- 000000 R-type: RegDst=1, ALUOp=0010 (funct), RegWrite=1.
- 011100 SPECIAL2: as R-type, but ALUOp=1000.
- 001000 ADDI / 001001 ADDIU: ALUSrc=1, ALUOp=0000, RegWrite=1.
- Logical immediates: ALUSrc=1, ZeroExt=1, RegWrite=1.
  - 001100 ANDI: ALUOp=0011.
  - 001101 ORI: ALUOp=0100.
  - 001110 XORI: ALUOp=0101.
- Compare immediates: ALUSrc=1, RegWrite=1.
  - 001010 SLTI: ALUOp=0110.
  - 001011 SLTIU: ALUOp=0111.
- 100011 LW: ALUSrc=1, ALUOp=0000, MemRead=1, MemtoReg=1, RegWrite=1.
- 101011 SW: ALUSrc=1, ALUOp=0000, MemWrite=1.
- Branches: ALUOp=0001, Branch=1.
  - 000100 BEQ: BranchNe=0.
  - 000101 BNE: BranchNe=1.
- Any other opcode: all controls 0, IllegalOp=1.
- Every control not listed for an opcode is 0. ALUOp is zero-extended to ALUOP_W.

**Destination register (computed in ID):**
- RegDst=1: rd [15:11].
- Otherwise: rt [20:16].
- If the destination is 0, RegWrite is forced to 0.

**Source usage for hazard detection:**
- rs is used by every decoded opcode.
- rt is used by R-type, SPECIAL2, SW, BEQ and BNE.

**Load-use hazard:**
- hazard = InstrValid & ID_EX.MemRead & (ID_EX.WriteReg != 0) & (ID_EX.WriteReg == used rs or used rt).
- Stall = hazard & ~Flush.

**Bubble:**
- ID/EX loads all-zero controls when any of these hold: ~InstrValid, Flush, hazard, or illegal opcode.
- IllegalOp is still latched into ID/EX when the bubble is caused by an illegal opcode, unless Flush is high.

**Pipeline advance:**
- EX/MEM and MEM/WB advance every cycle and are never held.
- The stage registers have no enable input; stalling upstream is the owner's job via Stall.

## Timing
- **Rst:** on a rising edge with Rst=1, every stage register clears. After reset all outputs are 0, including WB_WriteReg=0.
- **Stall after reset:** 0, since ID_EX.MemRead=0.
- **Reset mid-operation:** in-flight instructions are discarded with no partial writes. Rst overrides Flush and Stall.
- **Latency from decode:** EX outputs valid 1 cycle after decode, MEM 2 cycles, WB 3 cycles.
- **Load-use stall length:** exactly 1 cycle per load-use pair. On the next cycle the load is in MEM and hazard clears.
- **Stall with Flush:** Flush wins; Stall=0, bubble inserted.
- **Back-to-back loads to the same register:** each dependent consumer stalls once.

## Test plan
- **Reset:** Rst high for 2 cycles mid-stream, then low. Every output reads 0 on the cycle after release; Stall=0.
- **ADDI:** ADDI $t1,$t0,5 (0x21090005) with InstrValid=1.
  - Next cycle: EX_ALUSrc=1, EX_ALUOp=0000, EX_ZeroExt=0.
  - Two cycles after that: WB_RegWrite=1, WB_WriteReg=9.
- **Load-use:** LW $t1,0($t0) followed by ADD $t2,$t1,$t1.
  - Stall=1 for exactly one cycle.
  - EX shows an all-zero bubble; the ADD reaches EX one cycle later with EX_RegDst=1.
- **Flush during hazard:** assert Flush in the same cycle as the load-use hazard. Stall=0 and the ID/EX controls are zero.
- **Zero destination / SW:**
  - ADD $zero,... gives WB_RegWrite=0.
  - SW after LW to the rt register stalls 1 cycle; MEM_MemWrite=1 two cycles after the SW is accepted.
- **Illegal opcode / BNE:**
  - Opcode 111111 gives EX_IllegalOp=1 with all other controls 0.
  - BNE gives EX_Branch=1, EX_BranchNe=1, EX_ALUOp=0001.
